alu_issue_unit: RTL and testbench

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_unit_pkg.sv | 35 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_unit.sv | 136 +++++++++++++
 tb/tb_alu_issue_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: opcodes, FSM states, flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_issue_unit_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LS   = 4'b0011;
    localparam logic [3:0] OP_SRS  = 4'b0100;
    localparam logic [3:0] OP_URS  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_RRO  = 4'b1000;
    localparam logic [3:0] OP_LRO  = 4'b1001;
    localparam logic [3:0] OP_LOAD = 4'b1111;

    // Bit positions inside the 4-bit status register.
    localparam int FLAG_CR = 3;
    localparam int FLAG_OV = 2;
    localparam int FLAG_NG = 1;
    localparam int FLAG_ZR = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // 1010..1110 are unassigned and rejected.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'b1010) && (op <= 4'b1110);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4-entry register file: one synchronous write port, three asynchronous read ports.
// Latency: reads combinational; a write is visible after the writing clock edge.
// Backpressure: none; the write is taken whenever we_i is high.
// Ports: we_i/waddr_i/wdata_i write port; ra/rb operand reads; dbg debug read.
module alu_regfile #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [1:0]        rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [1:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one instruction at a time to an external ALU and writes the result back.
// Latency: accept edge N, done/illegal high in the cycle ending at edge N+2, next accept at edge N+3.
// Backpressure: instr_ready is high only in IDLE; one instruction in flight at a time.
// Ports: instr_valid/instr_ready/instr instruction handshake; alu_op/alu_a/alu_b out to the
// ALU and alu_out/alu_cr/alu_ov/alu_ng/alu_zr back; flags status; done/illegal completion
// pulses; dbg_addr/dbg_data debug register read.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter logic [3:0]  IDLE_OP = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cr,
    input  logic              alu_ov,
    input  logic              alu_ng,
    input  logic              alu_zr,
    output logic [3:0]        flags,
    output logic              done,
    output logic              illegal,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [3:0]        op_q;
    logic [1:0]        rd_q;
    logic [7:0]        imm_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [3:0]        flags_q, flags_d;
    logic              accept;
    logic              in_capture;
    logic              op_bad;
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] ra_data, rb_data;

    assign instr_ready = (state_q == ST_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign in_capture  = (state_q == ST_CAPTURE);
    assign op_bad      = is_illegal_op(op_q);
    assign wb_en       = in_capture && !op_bad;
    assign wb_data     = (op_q == OP_LOAD) ? DATA_W'(imm_q) : alu_out;

    assign done    = wb_en;
    assign illegal = in_capture && op_bad;
    assign alu_op  = alu_op_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign flags   = flags_q;

    // Read ports are addressed straight from the incoming word so the operands can be
    // registered on the accept edge; writeback happens two edges later, so a
    // destination that aliases a source is always read with its old value.
    alu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wb_en),
        .waddr_i    (rd_q),
        .wdata_i    (wb_data),
        .ra_addr_i  (instr[9:8]),
        .ra_data_o  (ra_data),
        .rb_addr_i  (instr[7:6]),
        .rb_data_o  (rb_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ADD/SUB own all four flags; other ALU ops refresh only sign/zero.
    // LOAD and rejected opcodes leave the status register untouched.
    always_comb begin
        flags_d = flags_q;
        if (wb_en) begin
            if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                flags_d = {alu_cr, alu_ov, alu_ng, alu_zr};
            end else if (op_q != OP_LOAD) begin
                flags_d[FLAG_NG] = alu_ng;
                flags_d[FLAG_ZR] = alu_zr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            alu_op_q <= IDLE_OP;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            flags_q  <= '0;
        end else begin
            flags_q <= flags_d;
            if (accept) begin
                op_q     <= instr[15:12];
                rd_q     <= instr[11:10];
                imm_q    <= instr[7:0];
                alu_op_q <= instr[15:12];
                alu_a_q  <= ra_data;
                alu_b_q  <= rb_data;
            end else if (in_capture) begin
                alu_op_q <= IDLE_OP;
                alu_a_q  <= '0;
                alu_b_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural ALU model on the ALU port.
// Latency: n/a.
// Backpressure: stimulus waits on instr_ready before each handshake.
module tb_alu_issue_unit;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [15:0] instr;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_cr, alu_ov, alu_ng, alu_zr;
    logic [3:0] flags;
    logic       done, illegal;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    logic [1:0] mon_dbg, stim_dbg;
    logic       stim_owns;
    assign dbg_addr = stim_owns ? stim_dbg : mon_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic            ill;
        logic [3:0]      op;
        logic [7:0]      a;
        logic [7:0]      b;
        logic [3:0][7:0] rf;   // {R3,R2,R1,R0} after writeback
        logic [3:0]      fl;
        logic [31:0]     acc;
    } exp_t;

    exp_t sb[$];

    alu_issue_unit #(.DATA_W(8), .IDLE_OP(4'b0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_cr      (alu_cr),
        .alu_ov      (alu_ov),
        .alu_ng      (alu_ng),
        .alu_zr      (alu_zr),
        .flags       (flags),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU. Unmodelled opcodes return a distinctive value with carry and
    // overflow set so that any wrongful writeback or flag update is visible.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = 9'd0;
        alu_out = 8'hA5;
        alu_cr  = 1'b1;
        alu_ov  = 1'b1;
        case (alu_op)
            4'b0010: begin
                alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = alu_sum[7:0];
                alu_cr  = alu_sum[8];
                alu_ov  = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
            end
            4'b0110: begin
                alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
                alu_out = alu_sum[7:0];
                alu_cr  = alu_sum[8];
                alu_ov  = (alu_a[7] != alu_b[7]) && (alu_sum[7] != alu_a[7]);
            end
            4'b0000: begin alu_out = alu_a & alu_b; alu_cr = 1'b0; alu_ov = 1'b0; end
            4'b0001: begin alu_out = alu_a | alu_b; alu_cr = 1'b0; alu_ov = 1'b0; end
            default: ;
        endcase
        alu_ng = alu_out[7];
        alu_zr = (alu_out == 8'h00);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic push(input logic ill, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [31:0] rf, input logic [3:0] fl,
                        input int acc);
        exp_t e;
        e.ill = ill; e.op = op; e.a = a; e.b = b; e.rf = rf; e.fl = fl; e.acc = acc;
        sb.push_back(e);
    endtask

    // Present a word and wait (bounded) for the handshake; returns at accept edge + 1.
    task automatic issue(input logic [15:0] w, input bit hold, output int acc, output int waited);
        waited = 0;
        acc    = -1;
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("issue_ready", {31'd0, instr_ready}, 32'd1);
        if (instr_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
        end
        if (!hold) instr_valid = 1'b0;
        instr = 16'hFFFF;   // must be ignored once latched
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        chk("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per done/illegal pulse.
    initial begin
        exp_t e;
        mon_dbg = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_n && (done || illegal)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {30'd0, done, illegal}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk("done", {31'd0, done}, {31'd0, !e.ill});
                    chk("alu_op", {28'd0, alu_op}, {28'd0, e.op});
                    chk("alu_a", {24'd0, alu_a}, {24'd0, e.a});
                    chk("alu_b", {24'd0, alu_b}, {24'd0, e.b});
                    // Pulse lies in the cycle that ends at accept edge + 2.
                    chk("latency", cyc, e.acc + 1);
                    @(posedge clk);
                    #1;
                    chk("pulse_len", {30'd0, done, illegal}, 32'd0);
                    chk("flags", {28'd0, flags}, {28'd0, e.fl});
                    chk("idle_op", {28'd0, alu_op}, 32'd0);
                    chk("idle_ab", {16'd0, alu_a, alu_b}, 32'd0);
                    for (int i = 0; i < 4; i++) begin
                        mon_dbg = 2'(i);
                        #1;
                        chk($sformatf("rf_R%0d", i), {24'd0, dbg_data}, {24'd0, e.rf[i]});
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_prev, w;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
        stim_owns = 1'b1; stim_dbg = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_ab", {16'd0, alu_a, alu_b}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_pulses", {30'd0, done, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            stim_dbg = 2'(i);
            #1;
            chk($sformatf("rst_R%0d", i), {24'd0, dbg_data}, 32'd0);
        end
        stim_owns = 1'b0;

        // LOAD R1=7F, LOAD R2=01, ADD R3=R1+R2, OR R0=R1|R2 (cr/ov held at 0/1)
        issue(16'hF47F, 0, acc, w); push(0, 4'hF, 8'h00, 8'h00, 32'h00_00_7F_00, 4'h0, acc);
        issue(16'hF801, 0, acc, w); push(0, 4'hF, 8'h00, 8'h00, 32'h00_01_7F_00, 4'h0, acc);
        issue(16'h2D80, 0, acc, w); push(0, 4'h2, 8'h7F, 8'h01, 32'h80_01_7F_00, 4'h6, acc);
        issue(16'h1180, 0, acc, w); push(0, 4'h1, 8'h7F, 8'h01, 32'h80_01_7F_7F, 4'h4, acc);
        // Illegal opcode 1100: nothing changes
        issue(16'hC000, 0, acc, w); push(1, 4'hC, 8'h7F, 8'h7F, 32'h80_01_7F_7F, 4'h4, acc);
        wait_drain();

        // Back-to-back with instr_valid held: LOAD R0=05, SUB R1=R0-R0, AND R2=R3&R3
        issue(16'hF005, 1, acc, w); push(0, 4'hF, 8'h7F, 8'h7F, 32'h80_01_7F_05, 4'h4, acc);
        acc_prev = acc;
        issue(16'h6400, 1, acc, w); push(0, 4'h6, 8'h05, 8'h05, 32'h80_01_00_05, 4'h1, acc);
        chk("bb_wait1", w, 2);
        chk("bb_gap1", acc - acc_prev, 3);
        acc_prev = acc;
        issue(16'h0BC0, 0, acc, w); push(0, 4'h0, 8'h80, 8'h80, 32'h80_80_00_05, 4'h2, acc);
        chk("bb_wait2", w, 2);
        chk("bb_gap2", acc - acc_prev, 3);

        // LOAD R2=10, ADD R2=R2+R2 (aliasing), ADD R0=R3+R3 (carry out)
        issue(16'hF810, 0, acc, w); push(0, 4'hF, 8'h05, 8'h05, 32'h80_10_00_05, 4'h2, acc);
        issue(16'h2A80, 0, acc, w); push(0, 4'h2, 8'h10, 8'h10, 32'h80_20_00_05, 4'h0, acc);
        issue(16'h23C0, 0, acc, w); push(0, 4'h2, 8'h80, 8'h80, 32'h80_20_00_00, 4'hD, acc);
        wait_drain();

        // Reset during ISSUE of ADD R3=R1+R2: aborted, outputs at reset values at once
        issue(16'h2D80, 0, acc, w);
        rst_n = 1'b0;
        #1;
        chk("abort_alu_op", {28'd0, alu_op}, 32'd0);
        chk("abort_ab", {16'd0, alu_a, alu_b}, 32'd0);
        chk("abort_flags", {28'd0, flags}, 32'd0);
        chk("abort_pulses", {30'd0, done, illegal}, 32'd0);
        stim_owns = 1'b1;
        stim_dbg  = 2'd3;
        #1;
        chk("abort_R3", {24'd0, dbg_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_ready", {31'd0, instr_ready}, 32'd1);
        chk("post_R3", {24'd0, dbg_data}, 32'd0);
        chk("post_flags", {28'd0, flags}, 32'd0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
